// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register with a 2-entry skid buffer.
// Registered in_ready, synchronous flush and a saturating stall counter.
module pipe_stage_skid_reg #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              valid_q;
  logic              rdy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              consume;

  assign accept  = in_valid & rdy_q;
  assign consume = valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      // stall counter saturates instead of wrapping
      if (valid_q && !out_ready && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_data;
            valid_q <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q <= in_data;
            rdy_q  <= 1'b0;
            state  <= FULL;
          end else if (consume) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_q <= skid_q;
            skid_q <= BUBBLE_VAL;
            rdy_q  <= 1'b1;
            state  <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign occupancy = state;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed plan plus random traffic
// checked against a queue-based reference model.
module tb_pipe_stage_skid_reg;

  localparam int          DW  = 32;
  localparam int          CW  = 3;
  localparam logic [31:0] BV  = 32'hB0BB_1E00;
  localparam int          MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  pipe_stage_skid_reg #(
    .DATA_W(DW),
    .BUBBLE_VAL(BV),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] q[$];
  logic [31:0] m_last = BV;
  int          m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit ov;
    bit acc;
    bit cons;
    if (reset) begin
      q.delete();
      m_last  = BV;
      m_stall = 0;
    end else if (flush) begin
      q.delete();
      m_last = BV;
    end else begin
      ov   = q.size() != 0;
      acc  = in_valid && q.size() < 2;
      cons = ov && out_ready;
      if (ov && !out_ready && m_stall < MAX) m_stall++;
      if (cons) m_last = q.pop_front();
      if (acc) q.push_back(in_data);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_d;
    exp_d = (q.size() != 0) ? q[0] : m_last;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_data", out_data, exp_d);
    chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
    reset     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #1;

    // reset then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_data", out_data, BV);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // streaming
    step(0, 0, 1, 32'h1000, 1);
    chk("stream0", out_data, 32'h1000);
    step(0, 0, 1, 32'h1004, 1);
    chk("stream1", out_data, 32'h1004);
    step(0, 0, 1, 32'h1008, 1);
    chk("stream2", out_data, 32'h1008);
    chk("stream_occ", 32'(occupancy), 32'd1);
    step(0, 0, 0, 0, 1);

    // backpressure into skid
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'hA, 0);
    step(0, 0, 1, 32'hB, 0);
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_ready", 32'(in_ready), 32'd0);
    step(0, 0, 1, 32'hC, 0);
    chk("bp_hold", out_data, 32'hA);
    chk("bp_stall", 32'(stall_cnt), 32'd2);
    step(0, 0, 1, 32'hC, 1);
    chk("bp_out_b", out_data, 32'hB);
    step(0, 0, 1, 32'hC, 1);
    chk("bp_out_c", out_data, 32'hC);
    step(0, 0, 0, 0, 1);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // flush while full
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h11, 0);
    step(0, 0, 1, 32'h22, 0);
    step(0, 1, 1, 32'hD, 0);
    chk("fl_data", out_data, BV);
    chk("fl_stall", 32'(stall_cnt), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("fl_gone", 32'(out_valid), 32'd0);

    // counter saturation
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h33, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("sat", 32'(stall_cnt), 32'(MAX));
    step(1, 0, 0, 0, 0);
    chk("sat_rst", 32'(stall_cnt), 32'd0);

    // reset beats flush and handshakes in FULL
    step(0, 0, 1, 32'h55, 0);
    step(0, 0, 1, 32'h66, 0);
    step(1, 1, 1, 32'h44, 1);
    chk("prio_occ", 32'(occupancy), 32'd0);
    chk("prio_data", out_data, BV);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)),
           $urandom,
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
